paddsb_arbiter: RTL and testbench
=================================

// Module: paddsb_arbiter
// PURPOSE
//  Shares one PADDSB saturating nibble adder (4 lanes x 4-bit signed) between two requesters.
//  Requesters are, for example, the EX-stage issue port and the vector-accumulate helper.
//  Round-robin arbitration, valid/ready handshakes and one registered output stage.
//  Result is returned with requester ID and tag.
//  Sits between issue logic and EX/MEM pipeline register; single PADDSB instance inside.
// PARAMETERS
//  TAG_W  4  width of opaque per-request tag echoed with result
//  CNT_W  8  width of per-requester saturation counters (only with PADDSB_OVCNT_EN)
// PORTS
//  clk          in   1      clock; all state updates on rising edge
//  rst_n        in   1      reset: synchronous, active-low
//  req_valid    in   2      request valid, bit i = requester i
//  req_ready    out  2      request accepted this cycle when valid&ready (one-hot or 0)
//  req_a        in   2x16   operand A per requester, packed {req1,req0}
//  req_b        in   2x16   operand B per requester, packed {req1,req0}
//  req_tag      in   2xTAG_W tag per requester, packed {req1,req0}
//  res_valid    out  1      result register holds valid data
//  res_ready    in   1      consumer accepts result when res_valid&res_ready
//  res_sum      out  16     saturated lane-wise sum
//  res_err      out  1      any lane saturated
//  res_lane_ov  out  4      per-lane overflow flags, bit k = nibble k
//  res_id       out  1      requester that issued this result
//  res_tag      out  TAG_W  tag of that request
//  ov_cnt       out  2xCNT_W saturation-event count per requester (PADDSB_OVCNT_EN only)
//  ov_clr       in   1      clear both counters (PADDSB_OVCNT_EN only)
// BEHAVIOUR
//  Reset (rst_n=0 at edge): res_valid=0, res_sum=0, res_err=0, res_lane_ov=0, res_id=0, res_tag=0.
//    Reset also sets rr_ptr=0 (requester 0 has priority) and ov_cnt=0.
//  Reset mid-transfer discards the held result; no partial handshake survives.
//  Output stage free when ~res_valid | res_ready (drain and refill in same cycle permitted).
//  Grant (combinational): if stage free, grant one valid requester.
//    Both valid -> grant index rr_ptr. One valid -> grant that one.
//    req_ready = one-hot grant. req_ready=0 when stage not free.
//  req_ready depends only on req_valid, rr_ptr, res_valid, res_ready; no loop through req_a/b.
//  On accept: operands of winner drive PADDSB. Next edge loads sum, lane flags, id and tag.
//    res_valid=1. Latency: exactly 1 cycle accept->res_valid.
//  rr_ptr <= ~winner after each accept; unchanged when nothing accepted.
//  Starvation bound: a continuously valid requester is granted within 2 accepts.
//  Stall: res_valid&~res_ready holds all res_* stable; req_ready=0.
//  Arithmetic: per lane k, s = A[4k+3:4k] + B[4k+3:4k] mod 16.
//    Positive overflow: both sign bits 0, s[3]=1 -> lane=4'h7, ov[k]=1.
//    Negative overflow: both sign bits 1, s[3]=0 -> lane=4'h8, ov[k]=1.
//    Otherwise lane=s, ov[k]=0. Each lane uses its own sign bits. No carry between lanes.
//  res_err = |res_lane_ov.
// CONFIGURATION
//  PADDSB_OVCNT_EN defined:
//    ov_cnt[i] += 1 on each accepted request from i whose result has err=1.
//    Increment happens at load edge. Counter saturates at all-ones; no wrap.
//    ov_clr has priority over a same-cycle increment and zeroes both counters.
//  PADDSB_OVCNT_EN undefined:
//    ov_cnt and ov_clr ports absent; no counter flops.
// STRUCTURE
//  Package paddsb_pkg: LANES=4, LANE_W=4, WORD_W=16, LANE_POS_SAT=4'h7, LANE_NEG_SAT=4'h8.
//    Also requester-ID type (1 bit) and NUM_REQ=2.
//  Sub-module rr_arb2: 2-way round-robin arbiter (valid, enable, ptr -> one-hot grant, ptr_next).
//  Saturating lane adder: the existing PADDSB datapath, instantiated once, combinational.
// TESTING
//  Reset then req0 only 0x1234+0x1111 -> next cycle res_valid=1, sum=0x2345, err=0, id=0.
//  req1 0x7777+0x1111 -> sum=0x7777, lane_ov=4'hF, err=1, id=1.
//    Repeat with 0x8888+0x8888 -> sum=0x8888, lane_ov=4'hF, err=1.
//  Both valid for 4 cycles, res_ready=1 -> accepts alternate id 0,1,0,1.
//    Tags echoed in order; one result per cycle.
//  res_ready=0 for 3 cycles with both valid -> req_ready=0, res_* stable.
//    Release -> no lost or duplicated request.
//  rst_n=0 while res_valid=1 and stalled -> next cycle res_valid=0, rr_ptr=0.
//  PADDSB_OVCNT_EN, CNT_W=2: five overflowing req0 ops -> ov_cnt[0]=3 (saturated).
//    ov_clr with same-cycle overflow -> 0.

Source files
------------

// File: rtl/paddsb_pkg.sv
// Shared constants and types for the PADDSB arbiter slice.
package paddsb_pkg;

    localparam int unsigned LANES   = 4;
    localparam int unsigned LANE_W  = 4;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned NUM_REQ = 2;

    localparam logic [LANE_W-1:0] LANE_POS_SAT = 4'h7;
    localparam logic [LANE_W-1:0] LANE_NEG_SAT = 4'h8;

    typedef logic req_id_t;

endpackage

// File: rtl/paddsb_add.sv
// PADDSB datapath: four independent 4-bit signed lanes with saturation, purely combinational.
module paddsb_add
    import paddsb_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [WORD_W-1:0] sum,
    output logic [LANES-1:0]  lane_ov
);

    always_comb begin
        logic [LANE_W-1:0] la;
        logic [LANE_W-1:0] lb;
        logic [LANE_W-1:0] s;
        sum     = '0;
        lane_ov = '0;
        la      = '0;
        lb      = '0;
        s       = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            la = a[k*LANE_W +: LANE_W];
            lb = b[k*LANE_W +: LANE_W];
            s  = la + lb;
            // Overflow only possible when both operands share a sign that the sum lost.
            if (!la[LANE_W-1] && !lb[LANE_W-1] && s[LANE_W-1]) begin
                sum[k*LANE_W +: LANE_W] = LANE_POS_SAT;
                lane_ov[k]              = 1'b1;
            end else if (la[LANE_W-1] && lb[LANE_W-1] && !s[LANE_W-1]) begin
                sum[k*LANE_W +: LANE_W] = LANE_NEG_SAT;
                lane_ov[k]              = 1'b1;
            end else begin
                sum[k*LANE_W +: LANE_W] = s;
            end
        end
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant when enabled, and the pointer value after the grant.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       ptr_next
);

    always_comb begin
        grant = '0;
        if (enable) begin
            if (valid == 2'b11) begin
                grant[ptr] = 1'b1;
            end else begin
                grant = valid;
            end
        end
        // The winner loses priority; an idle cycle leaves the pointer alone.
        if (grant[1]) begin
            ptr_next = 1'b0;
        end else if (grant[0]) begin
            ptr_next = 1'b1;
        end else begin
            ptr_next = ptr;
        end
    end

endmodule

// File: rtl/paddsb_arbiter.sv
// Shares one PADDSB adder between two requesters with round-robin grant and a registered result.
// Optional per-requester saturation counters: define PADDSB_OVCNT_EN.
module paddsb_arbiter
    import paddsb_pkg::*;
#(
    parameter int TAG_W = 4
`ifdef PADDSB_OVCNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [31:0]          req_a,
    input  logic [31:0]          req_b,
    input  logic [2*TAG_W-1:0]   req_tag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [15:0]          res_sum,
    output logic                 res_err,
    output logic [3:0]           res_lane_ov,
    output logic                 res_id,
    output logic [TAG_W-1:0]     res_tag
`ifdef PADDSB_OVCNT_EN
    ,
    output logic [2*CNT_W-1:0]   ov_cnt,
    input  logic                 ov_clr
`endif
);

    logic              rr_ptr;
    logic              ptr_next;
    logic              stage_free;
    logic [1:0]        grant;
    logic              accept;
    req_id_t           winner;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic [TAG_W-1:0]  op_tag;
    logic [WORD_W-1:0] add_sum;
    logic [LANES-1:0]  add_ov;
    req_id_t           id_q;

    assign stage_free = !res_valid || res_ready;

    rr_arb2 u_arb (
        .valid    (req_valid),
        .enable   (stage_free),
        .ptr      (rr_ptr),
        .grant    (grant),
        .ptr_next (ptr_next)
    );

    assign req_ready = grant;
    assign accept    = |grant;
    assign winner    = grant[1];

    assign op_a   = winner ? req_a[31:16] : req_a[15:0];
    assign op_b   = winner ? req_b[31:16] : req_b[15:0];
    assign op_tag = winner ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

    paddsb_add u_add (
        .a       (op_a),
        .b       (op_b),
        .sum     (add_sum),
        .lane_ov (add_ov)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= 1'b0;
            res_valid   <= 1'b0;
            res_sum     <= '0;
            res_lane_ov <= '0;
            id_q        <= 1'b0;
            res_tag     <= '0;
        end else begin
            rr_ptr <= ptr_next;
            if (accept) begin
                res_valid   <= 1'b1;
                res_sum     <= add_sum;
                res_lane_ov <= add_ov;
                id_q        <= winner;
                res_tag     <= op_tag;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

    assign res_id  = id_q;
    assign res_err = |res_lane_ov;

`ifdef PADDSB_OVCNT_EN
    logic [CNT_W-1:0] cnt [NUM_REQ];

    always_ff @(posedge clk) begin
        if (!rst_n || ov_clr) begin
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else if (accept && (|add_ov) && (cnt[winner] != '1)) begin
            cnt[winner] <= cnt[winner] + 1'b1;
        end
    end

    assign ov_cnt = {cnt[1], cnt[0]};
`endif

endmodule

// File: tb/tb_paddsb_arbiter.sv
// Randomised and directed check of paddsb_arbiter against a lane-arithmetic reference model.
module tb_paddsb_arbiter;

    localparam int TAG_W = 4;
    localparam int CNT_W = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [31:0]        req_a;
    logic [31:0]        req_b;
    logic [2*TAG_W-1:0] req_tag;
    logic               res_valid;
    logic               res_ready;
    logic [15:0]        res_sum;
    logic               res_err;
    logic [3:0]         res_lane_ov;
    logic               res_id;
    logic [TAG_W-1:0]   res_tag;
`ifdef PADDSB_OVCNT_EN
    logic [2*CNT_W-1:0] ov_cnt;
    logic               ov_clr;
`endif

    int total = 0;
    int bad   = 0;

    // Reference state: what the result register and priority must hold.
    bit         m_valid;
    bit [15:0]  m_sum;
    bit [3:0]   m_ov;
    bit         m_id;
    bit [3:0]   m_tag;
    bit         m_ptr;
    int         m_cnt [2];

    always #5 clk = ~clk;

    paddsb_arbiter #(
        .TAG_W(TAG_W)
`ifdef PADDSB_OVCNT_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_tag     (req_tag),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sum     (res_sum),
        .res_err     (res_err),
        .res_lane_ov (res_lane_ov),
        .res_id      (res_id),
        .res_tag     (res_tag)
`ifdef PADDSB_OVCNT_EN
        , .ov_cnt    (ov_cnt)
        , .ov_clr    (ov_clr)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Signed-integer view of a saturating nibble add.
    task automatic ref_add(input bit [15:0] a, input bit [15:0] b,
                           output bit [15:0] s, output bit [3:0] ov);
        int x, y, r;
        s  = '0;
        ov = '0;
        for (int k = 0; k < 4; k++) begin
            x = (a >> (4*k)) & 15;
            y = (b >> (4*k)) & 15;
            if (x >= 8) x -= 16;
            if (y >= 8) y -= 16;
            r = x + y;
            if (r > 7) begin
                r = 7;
                ov[k] = 1'b1;
            end else if (r < -8) begin
                r = -8;
                ov[k] = 1'b1;
            end
            s = s | (16'((r + 16) % 16) << (4*k));
        end
    endtask

    function automatic bit [1:0] ref_grant();
        if (m_valid && !res_ready) return 2'b00;
        if (req_valid == 2'b11) return m_ptr ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    // Checks outputs mid-cycle, then advances the model across the next rising edge.
    task automatic step();
        bit [1:0]  g;
        bit        w;
        bit [15:0] s;
        bit [3:0]  o;
        bit        clr;
        #1;
        g = ref_grant();
        chk("req_ready", 32'(req_ready), 32'(g));
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        if (m_valid) begin
            chk("res_sum", 32'(res_sum), 32'(m_sum));
            chk("res_lane_ov", 32'(res_lane_ov), 32'(m_ov));
            chk("res_err", 32'(res_err), 32'(|m_ov));
            chk("res_id", 32'(res_id), 32'(m_id));
            chk("res_tag", 32'(res_tag), 32'(m_tag));
        end
`ifdef PADDSB_OVCNT_EN
        chk("ov_cnt0", 32'(ov_cnt[CNT_W-1:0]), 32'(m_cnt[0]));
        chk("ov_cnt1", 32'(ov_cnt[2*CNT_W-1:CNT_W]), 32'(m_cnt[1]));
        clr = ov_clr;
`else
        clr = 1'b0;
`endif
        @(posedge clk);
        if (!rst_n) begin
            m_valid = 0; m_sum = 0; m_ov = 0; m_id = 0; m_tag = 0; m_ptr = 0;
            m_cnt[0] = 0; m_cnt[1] = 0;
        end else begin
            if (g != 2'b00) begin
                w = g[1];
                ref_add(w ? req_a[31:16] : req_a[15:0], w ? req_b[31:16] : req_b[15:0], s, o);
                m_valid = 1; m_sum = s; m_ov = o; m_id = w;
                m_tag = w ? req_tag[7:4] : req_tag[3:0];
                m_ptr = !w;
                if (!clr && o != 0 && m_cnt[w] < (1 << CNT_W) - 1) m_cnt[w]++;
            end else if (m_valid && res_ready) begin
                m_valid = 0;
            end
            if (clr) begin
                m_cnt[0] = 0;
                m_cnt[1] = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit [1:0] v, input bit [31:0] a, input bit [31:0] b,
                         input bit [7:0] t, input bit rr);
        req_valid = v;
        req_a     = a;
        req_b     = b;
        req_tag   = t;
        res_ready = rr;
    endtask

    initial begin
        bit [3:0] ids [4];
        rst_n = 1'b0;
        drive(2'b00, '0, '0, '0, 1'b0);
`ifdef PADDSB_OVCNT_EN
        ov_clr = 1'b0;
`endif
        m_valid = 0; m_ptr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
        @(negedge clk);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("reset res_valid", 32'(res_valid), 32'h0);
        chk("reset res_sum", 32'(res_sum), 32'h0);
        chk("reset res_tag", 32'(res_tag), 32'h0);

        // Single requester, plain sums and both saturation directions.
        drive(2'b01, 32'h0000_1234, 32'h0000_1111, 8'h05, 1'b1);
        step();
        chk("lit sum 2345", 32'(res_sum), 32'h2345);
        chk("lit err 0", 32'(res_err), 32'h0);
        chk("lit id 0", 32'(res_id), 32'h0);
        chk("lit valid", 32'(res_valid), 32'h1);
        drive(2'b10, 32'h7777_0000, 32'h1111_0000, 8'h90, 1'b1);
        step();
        chk("lit sum 7777", 32'(res_sum), 32'h7777);
        chk("lit ov F pos", 32'(res_lane_ov), 32'hF);
        chk("lit id 1", 32'(res_id), 32'h1);
        drive(2'b10, 32'h8888_0000, 32'h8888_0000, 8'hA0, 1'b1);
        step();
        chk("lit sum 8888", 32'(res_sum), 32'h8888);
        chk("lit ov F neg", 32'(res_lane_ov), 32'hF);
        chk("lit err 1", 32'(res_err), 32'h1);

        // Contention: grants must alternate starting from requester 0.
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 32'h0101_0202, 32'h0303_0404, 8'(((2*i+1) << 4) | (2*i)), 1'b1);
            step();
            ids[i] = {3'b0, res_id};
            chk("lit alt tag", 32'(res_tag), 32'((i % 2 == 0) ? 2*i : 2*i+1));
        end
        chk("lit alt ids", {ids[0], ids[1], ids[2], ids[3]}, 32'h0101);

        // Stall with both valid: nothing accepted, result frozen.
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 32'h1234_4321, 32'h0101_0101, 8'h3C, 1'b0);
            #1;
            chk("lit stall ready", 32'(req_ready), 32'h0);
            step();
        end
        drive(2'b11, 32'h1234_4321, 32'h0101_0101, 8'h3C, 1'b1);
        step();

        // Reset while a stalled result is held.
        drive(2'b11, 32'h1111_2222, 32'h3333_4444, 8'h12, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        chk("lit rst drop", 32'(res_valid), 32'h0);
        drive(2'b11, 32'h1111_2222, 32'h3333_4444, 8'h12, 1'b1);
        #1;
        chk("lit rst ptr", 32'(req_ready), 32'h1);
        step();

`ifdef PADDSB_OVCNT_EN
        drive(2'b00, '0, '0, '0, 1'b1);
        ov_clr = 1'b1;
        step();
        ov_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 32'h0000_7777, 32'h0000_1111, 8'h01, 1'b1);
            step();
        end
        chk("lit cnt sat", 32'(ov_cnt[CNT_W-1:0]), 32'h3);
        ov_clr = 1'b1;
        step();
        ov_clr = 1'b0;
        chk("lit cnt clr", 32'(ov_cnt[CNT_W-1:0]), 32'h0);
`endif

        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(2'($urandom), $urandom, $urandom, 8'($urandom), $urandom_range(0, 9) < 7);
`ifdef PADDSB_OVCNT_EN
            ov_clr = ($urandom_range(0, 15) == 0);
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
